// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Imported by the arbiter top and its sub-modules.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  // Watchdog counter must hold 0..timeout-1.
  function automatic int wd_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

  function automatic logic [7:0] hdr_byte(
    input logic [2:0] id
  );
    return {HDR_NIBBLE, 1'b0, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_drive-side handshakes of the arbiter.
// master = arbiter, slave = requesters plus uart_drive.
interface uart_tx_arbiter_if #(
  parameter int P_REQ_NUM = 4
);

  logic [8*P_REQ_NUM-1:0] i_req_data;
  logic [P_REQ_NUM-1:0]   i_req_valid;
  logic [P_REQ_NUM-1:0]   i_req_last;
  logic [P_REQ_NUM-1:0]   o_req_ready;
  logic [7:0]             o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready;

  modport master (
    input  i_req_data,
    input  i_req_valid,
    input  i_req_last,
    output o_req_ready,
    output o_tx_data,
    output o_tx_valid,
    input  i_tx_ready
  );

  modport slave (
    output i_req_data,
    output i_req_valid,
    output i_req_last,
    input  o_req_ready,
    input  o_tx_data,
    input  o_tx_valid,
    output i_tx_ready
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Round-robin winner select over a request vector.
// Pointer moves to owner+1 when adv_i pulses.
module uart_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  input  logic [IW-1:0] owner_i,
  output logic          any_o,
  output logic [IW-1:0] win_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;

  // Scan downward so the slot nearest the pointer wins last.
  always_comb begin
    any_o     = 1'b0;
    win_idx_o = '0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (req_i[cand[IW-1:0]]) begin
        any_o     = 1'b1;
        win_idx_o = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      if (owner_i == IW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = owner_i + IW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin share of one uart_drive TX channel,
// with optional channel header and a stall watchdog.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int P_REQ_NUM    = 4,
  parameter int P_ADD_HEADER = 1,
  parameter int P_TIMEOUT    = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  uart_tx_arbiter_if.master    bus,
  output logic [P_REQ_NUM-1:0] o_grant,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int IW = $clog2(P_REQ_NUM);
  localparam int WW = wd_width(P_TIMEOUT);

  state_e               state_q, state_d;
  logic [P_REQ_NUM-1:0] grant_q, grant_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [WW-1:0]        wd_q, wd_d;

  logic          win_any;
  logic [IW-1:0] win_idx;
  logic          adv;
  logic          free;
  logic          own_valid;
  logic          own_last;
  logic [7:0]    own_data;
  logic          accept;
  logic          hdr_load;
  logic          wd_hit;

  uart_rr_arbiter #(
    .N  (P_REQ_NUM),
    .IW (IW)
  ) u_rr (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .req_i     (bus.i_req_valid),
    .adv_i     (adv),
    .owner_i   (owner_q),
    .any_o     (win_any),
    .win_idx_o (win_idx)
  );

  assign free      = !tx_valid_q || bus.i_tx_ready;
  assign own_valid = bus.i_req_valid[owner_q];
  assign own_last  = bus.i_req_last[owner_q];
  assign own_data  = bus.i_req_data[{owner_q, 3'b000} +: 8];

  assign accept = (state_q == S_DATA) && own_valid && free;
  assign wd_hit = (state_q == S_DATA) && !own_valid
               && (wd_q == WW'(P_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    wd_d     = wd_q;
    adv      = 1'b0;
    hdr_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (win_any) begin
          owner_d = win_idx;
          grant_d = P_REQ_NUM'(1) << win_idx;
          state_d = (P_ADD_HEADER != 0) ? S_HEAD : S_DATA;
        end
      end
      S_HEAD: begin
        if (free) begin
          hdr_load = 1'b1;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          wd_d = '0;
          if (own_last) begin
            adv     = 1'b1;
            grant_d = '0;
            state_d = S_IDLE;
          end
        end else if (wd_hit) begin
          adv     = 1'b1;
          grant_d = '0;
          wd_d    = '0;
          state_d = S_IDLE;
        end else if (!own_valid) begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A stalled owner (valid, sink not ready) leaves the watchdog alone.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (hdr_load) begin
      tx_data_d  = hdr_byte(3'(owner_q));
      tx_valid_d = 1'b1;
    end else if (accept) begin
      tx_data_d  = own_data;
      tx_valid_d = 1'b1;
    end else if (bus.i_tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wd_q       <= wd_d;
    end
  end

  assign bus.o_req_ready = (state_q == S_DATA && free) ? grant_q : '0;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_valid  = tx_valid_q;

  assign o_grant   = grant_q;
  assign o_busy    = (state_q != S_IDLE) || tx_valid_q;
  assign o_timeout = wd_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Random and directed stimulus against a packet-level
// round-robin reference model of uart_tx_arbiter.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] o_grant;
  logic          o_busy;
  logic          o_timeout;

  uart_tx_arbiter_if #(.P_REQ_NUM(NR)) bus ();

  uart_tx_arbiter #(
    .P_REQ_NUM    (NR),
    .P_ADD_HEADER (1),
    .P_TIMEOUT    (16)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic [8:0] sq [NR][$];
  int exp_tx[$];
  int exp_own[$];
  int mptr;
  int first_own;
  int first_tx_cyc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.i_req_data  = '0;
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    bus.i_tx_ready  = 1'b1;
  endtask

  task automatic push_b(input int r, input int d, input bit l);
    sq[r].push_back({l, 8'(d)});
  endtask

  // Packet order from pending queues: first non-empty at/after pointer.
  task automatic plan();
    logic [8:0] cq [NR][$];
    logic [8:0] b;
    int w;
    bit more;
    for (int i = 0; i < NR; i++) cq[i] = sq[i];
    more = 1'b1;
    while (more) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        int r;
        r = (mptr + k) % NR;
        if (w < 0 && cq[r].size() > 0) w = r;
      end
      if (w < 0) begin
        more = 1'b0;
      end else begin
        exp_own.push_back(w);
        exp_tx.push_back(32'hA0 | w);
        do begin
          b = cq[w].pop_front();
          exp_tx.push_back(int'(b[7:0]));
        end while (!b[8]);
        mptr = (w + 1) % NR;
      end
    end
  endtask

  task automatic run(input int rdy_pct, input int gap_pct,
                     input int stall_at, input int budget);
    int  cyc;
    int  txn;
    int  stall_left;
    bit  stalled;
    bit  gap;
    int  gapc [NR];
    bit  started [NR];
    bit  hold_v;
    logic [7:0] hold_d;
    cyc = 0;
    txn = 0;
    stall_left = 0;
    hold_v = 1'b0;
    hold_d = '0;
    first_own = -1;
    first_tx_cyc = -1;
    for (int r = 0; r < NR; r++) begin
      gapc[r] = 0;
      started[r] = 1'b0;
    end
    while (exp_tx.size() > 0 && cyc < budget) begin
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (sq[r].size() > 0) begin
          gap = started[r] && gapc[r] < 4
             && ($urandom_range(99) < gap_pct);
          if (gap) gapc[r]++;
          bus.i_req_valid[r] = !gap;
          bus.i_req_data[r*8 +: 8] = sq[r][0][7:0];
          bus.i_req_last[r] = sq[r][0][8];
        end else begin
          bus.i_req_valid[r] = 1'b0;
          bus.i_req_last[r] = 1'b0;
        end
      end
      stalled = (stall_left > 0);
      if (stalled) begin
        stall_left--;
        bus.i_tx_ready = 1'b0;
      end else begin
        bus.i_tx_ready = ($urandom_range(99) < rdy_pct);
      end
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("stall_rdy", bus.o_req_ready, 0);
        chk("stall_vld", bus.o_tx_valid, 1);
      end
      if (hold_v) chk("hold", bus.o_tx_data, hold_d);
      hold_v = bus.o_tx_valid && !bus.i_tx_ready;
      hold_d = bus.o_tx_data;
      if (|bus.o_req_ready)
        chk("onehot", $countones(bus.o_req_ready), 1);
      for (int r = 0; r < NR; r++) begin
        if (bus.i_req_valid[r] && bus.o_req_ready[r]) begin
          chk("own", r, exp_own.size() > 0 ? exp_own[0] : -1);
          chk("grant", o_grant, 1 << r);
          if (first_own < 0) first_own = r;
          if (sq[r][0][8]) begin
            void'(exp_own.pop_front());
            started[r] = 1'b0;
          end else begin
            started[r] = 1'b1;
          end
          void'(sq[r].pop_front());
          gapc[r] = 0;
        end
      end
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        chk("tx", bus.o_tx_data,
            exp_tx.size() > 0 ? exp_tx.pop_front() : -1);
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        txn++;
        if (txn == stall_at) stall_left = 50;
      end
      if (o_timeout) chk("tmo", o_timeout, 0);
    end
    chk("budget", exp_tx.size(), 0);
    exp_tx.delete();
    exp_own.delete();
    for (int r = 0; r < NR; r++) sq[r].delete();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  int acc;
  int n;
  int t5q[$];

  initial begin
    total = 0;
    bad = 0;
    mptr = 0;
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", o_grant, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_tmo", o_timeout, 0);
    chk("rst_txv", bus.o_tx_valid, 0);
    chk("rst_rdy", bus.o_req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single 3-byte packet from req1
    push_b(1, 8'h11, 0);
    push_b(1, 8'h22, 0);
    push_b(1, 8'h33, 1);
    plan();
    run(100, 0, 0, 200);
    chk("t1_lat", first_tx_cyc, 3);
    @(negedge clk);
    chk("t1_grant", o_grant, 0);
    chk("t1_busy", o_busy, 0);

    // simultaneous one-byte requests from 0, 2, 3
    push_b(0, 8'hC0, 1);
    push_b(2, 8'hC2, 1);
    push_b(3, 8'hC3, 1);
    plan();
    run(100, 0, 0, 200);

    // req3 alone, then req3 and req0 together
    push_b(3, 8'h31, 1);
    plan();
    run(100, 0, 0, 200);
    push_b(3, 8'h32, 1);
    push_b(0, 8'h01, 1);
    plan();
    run(100, 0, 0, 200);
    chk("t3_wrap", first_own, 0);

    // 50-cycle sink stall mid-packet
    for (int i = 0; i < 8; i++) push_b(2, 8'h40 + i, i == 7);
    plan();
    run(100, 0, 4, 300);

    // watchdog release of req2, req1 served next
    t5q = '{32'hA2, 32'h51, 32'h52};
    @(posedge clk);
    #1;
    bus.i_req_valid[2] = 1'b1;
    bus.i_req_data[23:16] = 8'h51;
    bus.i_req_last[2] = 1'b0;
    acc = 0;
    n = 0;
    while (acc < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.o_tx_valid && bus.i_tx_ready)
        chk("t5_tx", bus.o_tx_data,
            t5q.size() > 0 ? t5q.pop_front() : -1);
      if (bus.i_req_valid[2] && bus.o_req_ready[2]) acc++;
      @(posedge clk);
      #1;
      if (acc == 1) bus.i_req_data[23:16] = 8'h52;
      if (acc == 2) begin
        bus.i_req_valid[2] = 1'b0;
        bus.i_req_valid[1] = 1'b1;
        bus.i_req_data[15:8] = 8'h61;
        bus.i_req_last[1] = 1'b1;
      end
    end
    chk("t5_acc", acc, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.o_tx_valid && bus.i_tx_ready)
        chk("t5_tx", bus.o_tx_data,
            t5q.size() > 0 ? t5q.pop_front() : -1);
    end while (!o_timeout && n < 40);
    chk("t5_cnt", n, 16);
    chk("t5_drain", t5q.size(), 0);
    @(negedge clk);
    chk("t5_pulse", o_timeout, 0);
    chk("t5_rel", o_grant, 0);
    @(negedge clk);
    chk("t5_next", o_grant, 4'b0010);
    mptr = 3;
    push_b(1, 8'h61, 1);
    plan();
    run(100, 0, 0, 200);

    // random packets, random sink readiness, short valid gaps
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int r = 0; r < NR; r++) begin
        int np;
        np = $urandom_range(2);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(5, 1);
          for (int i = 0; i < len; i++)
            push_b(r, $urandom_range(255), i == len - 1);
        end
      end
      if (sq[0].size() == 0) push_b(0, $urandom_range(255), 1);
      plan();
      run($urandom_range(100, 30), 25, 0, 3000);
    end

    // reset mid-packet with a byte held in the output register
    @(posedge clk);
    #1;
    bus.i_tx_ready = 1'b0;
    bus.i_req_valid[1] = 1'b1;
    bus.i_req_data[15:8] = 8'h71;
    bus.i_req_last[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_tx_valid && n < 20);
    chk("t6_txv", bus.o_tx_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_txv0", bus.o_tx_valid, 0);
    chk("t6_grant", o_grant, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_rdy", bus.o_req_ready, 0);
    @(posedge clk);
    #1;
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    push_b(1, 8'h81, 1);
    push_b(0, 8'h90, 0);
    push_b(0, 8'h91, 1);
    plan();
    run(100, 0, 0, 200);
    chk("t6_first", first_own, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
